// File: rtl/mul32acc_seq_pkg.sv
// mul32acc_seq_pkg
// Shared definitions for the iterative multiply-accumulate p = a*b + c.
//   state_t  : FSM encoding (IDLE, RUN, DONE)
//   K_DEF    : default operand width
//   BPC_DEF  : default multiplier bits retired per cycle
//   CNT_W    : iteration counter width for the default configuration
//   cnt_w()  : counter width for any legal (K, BPC)
//   bpc_ok() : legality of a (K, BPC) pair, used as an elaboration check
package mul32acc_seq_pkg;

  localparam int K_DEF   = 32;
  localparam int BPC_DEF = 2;
  localparam int CNT_W   = $clog2(K_DEF / BPC_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guard against a zero-width counter when only one iteration is needed.
  function automatic int cnt_w(input int k, input int bpc);
    return ((k / bpc) > 1) ? $clog2(k / bpc) : 1;
  endfunction

  function automatic bit bpc_ok(input int k, input int bpc);
    return ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) && ((k % bpc) == 0);
  endfunction

endpackage

// File: rtl/mul32acc_seq_if.sv
// mul32acc_seq_if
// Operand/result bus of the multiply-accumulate.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the payload must be stable while valid is high, and valid must not
// depend on ready. The input side carries a, b, c; the output side carries p, err.
//   master : drives in_valid, a, b, c, out_ready (the requester)
//   slave  : drives in_ready, out_valid, p, err  (the multiplier)
// Parameter K : operand width (p is 2K bits).
interface mul32acc_seq_if #(
  parameter int K = 32
);
  logic           in_valid;
  logic           in_ready;
  logic [K-1:0]   a;
  logic [K-1:0]   b;
  logic [K-1:0]   c;
  logic           out_valid;
  logic           out_ready;
  logic [2*K-1:0] p;
  logic           err;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, p, err
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, p, err
  );
endinterface

// File: rtl/mul32acc_seq_mul_step.sv
// mul32acc_seq_mul_step
// Combinational shift-add step: retires BPC multiplier bits in one go.
//   acc_i/acc_o : 2K-bit running sum
//   mc_i/mc_o   : 2K-bit multiplicand, shifted left once per retired bit
//   mp_i/mp_o   : K-bit multiplier, shifted right once per retired bit
module mul32acc_seq_mul_step #(
  parameter int K   = 32,
  parameter int BPC = 2
) (
  input  logic [2*K-1:0] acc_i,
  input  logic [2*K-1:0] mc_i,
  input  logic [K-1:0]   mp_i,
  output logic [2*K-1:0] acc_o,
  output logic [2*K-1:0] mc_o,
  output logic [K-1:0]   mp_o
);

  logic [2*K-1:0] acc_t;
  logic [2*K-1:0] mc_t;
  logic [K-1:0]   mp_t;

  // Sums never exceed 2^2K - 2^K, so the 2K-bit add cannot overflow.
  always_comb begin
    acc_t = acc_i;
    mc_t  = mc_i;
    mp_t  = mp_i;
    for (int i = 0; i < BPC; i++) begin
      if (mp_t[0]) acc_t = acc_t + mc_t;
      mc_t = mc_t << 1;
      mp_t = mp_t >> 1;
    end
    acc_o = acc_t;
    mc_o  = mc_t;
    mp_o  = mp_t;
  end

endmodule

// File: rtl/mul32acc_seq.sv
// mul32acc_seq
// Iterative unsigned multiply-accumulate p = a*b + c at 2K-bit width; the
// inverse of the 2K/K divider (a=quotient, b=divisor, c=remainder).
// Result appears exactly K/BPC edges after the accept edge; one result per
// K/BPC + 2 cycles; latency is data independent.
// Ports:
//   clk        clock
//   rstn       asynchronous active-low reset
//   bus        mul32acc_seq_if.slave (in_valid/in_ready/a/b/c, out_valid/out_ready/p/err)
//   dbg_state  current FSM state
// Build option: define MUL_REM_CHECK_EN to flag c >= b on err while the result
// is valid (an illegal divider remainder); otherwise err is tied low.
module mul32acc_seq
  import mul32acc_seq_pkg::*;
#(
  parameter int K   = K_DEF,
  parameter int BPC = BPC_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  mul32acc_seq_if.slave bus,
  output state_t        dbg_state
);

  localparam int CW = cnt_w(K, BPC);
  localparam logic [CW-1:0] CNT_LOAD = CW'(K / BPC - 1);

  if (!bpc_ok(K, BPC)) begin : g_bad_cfg
    $error("mul32acc_seq: BPC must be 1, 2, 4 or 8 and divide K");
  end

  state_t         state_q, state_d;
  logic [2*K-1:0] acc_q, acc_d;
  logic [2*K-1:0] mc_q, mc_d;
  logic [K-1:0]   mp_q, mp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*K-1:0] p_q, p_d;
  logic           out_valid_q, out_valid_d;
`ifdef MUL_REM_CHECK_EN
  logic           err_q, err_d;
`endif

  logic [2*K-1:0] acc_n;
  logic [2*K-1:0] mc_n;
  logic [K-1:0]   mp_n;

  mul32acc_seq_mul_step #(.K(K), .BPC(BPC)) u_step (
    .acc_i (acc_q),
    .mc_i  (mc_q),
    .mp_i  (mp_q),
    .acc_o (acc_n),
    .mc_o  (mc_n),
    .mp_o  (mp_n)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mc_d        = mc_q;
    mp_d        = mp_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
`ifdef MUL_REM_CHECK_EN
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone means accept.
        if (bus.in_valid) begin
          acc_d   = {{K{1'b0}}, bus.c};
          mc_d    = {{K{1'b0}}, bus.a};
          mp_d    = bus.b;
          cnt_d   = CNT_LOAD;
          state_d = RUN;
`ifdef MUL_REM_CHECK_EN
          err_d   = (bus.c >= bus.b);
`endif
        end
      end
      RUN: begin
        acc_d = acc_n;
        mc_d  = mc_n;
        mp_d  = mp_n;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          p_d         = acc_n;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // No bypass: the next accept can only happen once back in IDLE.
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mc_q        <= '0;
      mp_q        <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef MUL_REM_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mc_q        <= mc_d;
      mp_q        <= mp_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
`ifdef MUL_REM_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.p         = p_q;
`ifdef MUL_REM_CHECK_EN
  assign bus.err       = out_valid_q & err_q;
`else
  assign bus.err       = 1'b0;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mul32acc_seq.sv
// tb_mul32acc_seq
// Directed bench for mul32acc_seq (K=32, BPC=2): basic, divider round-trip,
// extremes, backpressure, reset mid-run and remainder-consistency flag.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mul32acc_seq;
  import mul32acc_seq_pkg::*;

  localparam int K   = 32;
  localparam int LAT = 16;
`ifdef MUL_REM_CHECK_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  state_t dbg_state;
  int     checks   = 0;
  int     failures = 0;
  logic [2*K-1:0] exp_q[$];

  mul32acc_seq_if #(.K(K)) bus ();

  mul32acc_seq #(.K(K), .BPC(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Presents one operand set, tracks latency and busy-ness, checks the result,
  // optionally holds out_ready low for `hold` cycles, then lets it be consumed.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [63:0] exp_p,
                        input logic exp_err, input int hold);
    int          lat;
    bit          busy_ok;
    logic [63:0] exp;
    exp_q.push_back(exp_p);
    @(negedge clk);
    bus.out_ready = (hold == 0);
    bus.a = a; bus.b = b; bus.c = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    // Scramble operands after accept; they must not matter any more.
    bus.in_valid = 1'b0;
    bus.a = ~a; bus.b = ~b; bus.c = ~c;
    lat = 0;
    busy_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(LAT));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    exp = exp_q.pop_front();
    check({tag, "_p"}, bus.p, exp);
    check({tag, "_err"}, 64'(bus.err), 64'(exp_err & REM_EN));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = i[0];
      bus.a = $urandom_range(0, 1000);
      bus.b = $urandom_range(0, 1000);
      @(negedge clk);
      check({tag, "_hold_p"}, bus.p, exp);
      check({tag, "_hold_valid"}, {bus.out_valid, bus.in_ready}, 64'b10);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_consumed"}, {bus.out_valid, bus.in_ready, bus.err}, 64'b010);
    check({tag, "_idle"}, 64'(dbg_state), 64'(IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = '0; bus.b = '0; bus.c = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_p", bus.p, 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    rstn = 1'b1;

    run_op("basic", 32'd7, 32'd3, 32'd2, 64'h17, 1'b0, 0);
    run_op("divrt", 32'h12345678, 32'h00010000, 32'h9ABC, 64'h0000_1234_5678_9ABC, 1'b0, 0);
    run_op("max", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFF_FFFF_0000_0000, 1'b1, 0);
    run_op("a_zero", 32'h0, 32'hFFFFFFFF, 32'h5, 64'h5, 1'b0, 0);
    run_op("b_zero", 32'h1234, 32'h0, 32'h77, 64'h77, 1'b1, 0);
    run_op("bkpr", 32'hDEADBEEF, 32'h10, 32'h3, 64'h0000_000D_EADB_EEF3, 1'b0, 10);
    run_op("after_bkpr", 32'h1000, 32'h1000, 32'h1, 64'h0100_0001, 1'b0, 0);

    // Reset mid-run: abort 5 cycles after accept.
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.a = 32'hFFFF; bus.b = 32'hFFFF; bus.c = 32'h1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midrun_state", 64'(dbg_state), 64'(RUN));
    repeat (5) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrun_rst", {bus.out_valid, bus.in_ready, bus.err}, 64'b010);
    check("midrun_rst_p", bus.p, 64'd0);
    check("midrun_rst_state", 64'(dbg_state), 64'(IDLE));
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) @(negedge clk);
    check("midrun_no_result", 64'(bus.out_valid), 64'd0);
    run_op("rst_next", 32'd2, 32'd2, 32'd0, 64'd4, 1'b0, 0);

    // Remainder-consistency cases.
    run_op("rem_eq", 32'd1, 32'd5, 32'd5, 64'hA, 1'b1, 0);
    run_op("rem_b0", 32'd9, 32'd0, 32'd0, 64'h0, 1'b1, 0);
    run_op("rem_ok", 32'd100, 32'd7, 32'd6, 64'd706, 1'b0, 0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul32acc_seq.md
Name: mul32acc_seq

Overview:
- Iterative multiply-accumulate that computes p = a*b + c at full 2K-bit width.
- It is the inverse of the team's pipelined 2K/K divider: feeding it a = quotient, b = divisor, c = remainder rebuilds the dividend.
- Used to check divider results and to reconstruct operands in the arithmetic datapath.
- Uses a valid/ready handshake on both input and output; processes BPC multiplier bits per clock.

Parameters:
- K, 32, operand width; the product p is 2K bits wide.
- BPC, 2, multiplier bits retired per cycle; must divide K evenly (allowed values 1, 2, 4, 8).

Ports:
- clk  input  1  clock
- rstn  input  1  reset, asynchronous, active-low
- in_valid  input  1  operands a, b, c are presented
- in_ready  output  1  block can accept operands
- a  input  K  multiplicand (divider quotient)
- b  input  K  multiplier (divider divisor)
- c  input  K  addend (divider remainder), zero-extended to 2K
- out_valid  output  1  result p is valid
- out_ready  input  1  downstream accepts p
- p  output  2K  result a*b + c
- err  output  1  remainder-consistency flag (see Optional Feature)

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, p=0, err=0. All internal registers are cleared.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0:
    - load acc <= {K'b0, c}
    - load mc <= {K'b0, a}
    - load mp <= b
    - load cnt <= K/BPC - 1
    - go to RUN
  - RUN: in_ready=0. On each edge, repeat BPC times in sequence:
    - if mp[0], acc += mc
    - mc <<= 1
    - mp >>= 1
    - Then decrement cnt. On the edge where cnt==0: p <= final acc, out_valid <= 1, go to DONE.
  - DONE: out_valid=1 and p is held stable. On out_valid&&out_ready: out_valid <= 0, go to IDLE.
- Latency:
  - out_valid rises exactly K/BPC edges after the accept edge E0 (16 with the defaults).
  - Throughput is one result per K/BPC + 2 cycles.
  - No early termination; latency does not depend on the data.
- Arithmetic:
  - All additions are 2K bits, unsigned.
  - The maximum result, (2^K-1)^2 + (2^K-1) = 2^2K - 2^K, fits in 2K bits, so no overflow is possible and no carry-out is kept.
- Handshake rules:
  - Inputs are sampled only on the accept edge. Changes to a, b, c afterwards have no effect.
  - in_ready is combinational from state (state==IDLE) and does not depend on out_ready.
  - No bypass path: a new operation cannot be accepted in the same cycle that a result is consumed.
  - in_valid asserted during RUN or DONE is ignored and not queued.
- Edge cases:
  - b=0 gives p=c; a=0 gives p=c; both still take the full latency.
  - out_ready may be held high before out_valid rises; the result is then consumed in its first DONE cycle.
- Reset mid-operation: asserting rstn low at any time aborts the operation immediately and restores the reset values. No result is emitted afterwards.

Optional Feature:
- Macro: MUL_REM_CHECK_EN
- Defined:
  - On the accept edge, register err_q <= (c >= b).
  - err is driven from err_q while out_valid=1, otherwise 0.
  - This flags that (a, b, c) cannot be a legal divider output, since a legal remainder is always less than the divisor. The case b=0 is always flagged.
  - p is still computed normally.
- Undefined: no err_q register; err is tied to 0.

Decomposition:
- Shared package:
  - state enum: IDLE, RUN, DONE
  - constant CNT_W = $clog2(K/BPC)
  - elaboration check that K % BPC == 0
- Natural sub-module: mul_step (combinational). Inputs acc, mc, mp; outputs next acc, mc, mp after BPC bits. It is instantiated once in the RUN datapath.

Test Plan:
1. Basic: a=7, b=3, c=2, out_ready=1 → out_valid exactly 16 edges after accept; p=0x17; in_ready=0 throughout RUN and DONE.
2. Divider round-trip: a=0x12345678, b=0x00010000, c=0x9ABC → p=0x0000123456789ABC; with MUL_REM_CHECK_EN, err=0.
3. Maximum: a=b=c=0xFFFFFFFF → p=0xFFFFFFFF00000000. Also a=0, b=0xFFFFFFFF, c=0x5 → p=0x5.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid → p is stable and in_valid pulses are ignored; when out_ready rises, IDLE follows next cycle and a new operand set is accepted and correct.
5. Reset mid-run: assert rstn low 5 cycles after accept → out_valid=0, p=0, in_ready=1 immediately; the next operation a=2, b=2, c=0 gives p=4.
6. With MUL_REM_CHECK_EN: a=1, b=5, c=5 → p=0xA, err=1 while out_valid. With b=0, c=0 → err=1. With the macro undefined, err stays 0 in all tests.
